// File: rtl/imm_gen_pipe.sv
// RV32I immediate generator: decodes I/S/B/U/J immediates, sign-extends to XLEN, adds pc for targets.
// Latency 1 cycle; output register plus one skid entry, in_ready = !skid_full (registered). Optional: IMM_GEN_ILLEGAL_EN.
module imm_gen_pipe #(
  parameter int XLEN = 32,
  parameter int PC_W = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     instr_in,
  input  logic [PC_W-1:0] pc_in,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] imm_out,
  output logic [2:0]      fmt_out,
  output logic [XLEN-1:0] target_out,
  output logic            target_vld_out,
  output logic            illegal_out
);

  localparam logic [2:0] FMT_NONE = 3'd0;
  localparam logic [2:0] FMT_I    = 3'd1;
  localparam logic [2:0] FMT_S    = 3'd2;
  localparam logic [2:0] FMT_B    = 3'd3;
  localparam logic [2:0] FMT_U    = 3'd4;
  localparam logic [2:0] FMT_J    = 3'd5;

  typedef struct packed {
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] target;
    logic [2:0]      fmt;
    logic            tvld;
    logic            illegal;
  } res_t;

  res_t               dec;
  res_t               out_q, out_d;
  res_t               skid_q, skid_d;
  logic               out_vld_q, out_vld_d;
  logic               skid_vld_q, skid_vld_d;
  logic               rdy_q;
  logic               accept, xfer;
  logic signed [31:0] imm32;
  logic [2:0]         fmt;

  always_comb begin
    imm32 = '0;
    fmt   = FMT_NONE;
    case (instr_in[6:0])
      7'b0000011, 7'b0010011, 7'b1100111, 7'b0001111, 7'b1110011: begin
        fmt   = FMT_I;
        imm32 = {{20{instr_in[31]}}, instr_in[31:20]};
      end
      7'b0100011: begin
        fmt   = FMT_S;
        imm32 = {{20{instr_in[31]}}, instr_in[31:25], instr_in[11:7]};
      end
      7'b1100011: begin
        fmt   = FMT_B;
        imm32 = {{20{instr_in[31]}}, instr_in[7], instr_in[30:25], instr_in[11:8], 1'b0};
      end
      7'b0110111, 7'b0010111: begin
        fmt   = FMT_U;
        imm32 = {instr_in[31:12], 12'b0};
      end
      7'b1101111: begin
        fmt   = FMT_J;
        imm32 = {{12{instr_in[31]}}, instr_in[19:12], instr_in[20], instr_in[30:21], 1'b0};
      end
      default: begin
        fmt   = FMT_NONE;
        imm32 = '0;
      end
    endcase
`ifdef IMM_GEN_ILLEGAL_EN
    // Compressed/reserved encodings are not decoded here.
    if (instr_in[1:0] != 2'b11) begin
      fmt   = FMT_NONE;
      imm32 = '0;
    end
`endif
    dec.fmt     = fmt;
    dec.imm     = XLEN'(imm32);
    dec.target  = XLEN'(pc_in) + XLEN'(imm32);
    dec.tvld    = (fmt == FMT_B) || (fmt == FMT_J);
`ifdef IMM_GEN_ILLEGAL_EN
    dec.illegal = (fmt == FMT_NONE) && (instr_in[6:0] != 7'b0110011);
`else
    dec.illegal = 1'b0;
`endif
  end

  assign accept = in_valid && rdy_q;
  assign xfer   = out_vld_q && out_ready;

  always_comb begin
    out_d      = out_q;
    out_vld_d  = out_vld_q;
    skid_d     = skid_q;
    skid_vld_d = skid_vld_q;
    if (xfer) begin
      if (skid_vld_q) begin
        out_d      = skid_q;
        skid_vld_d = accept;
        if (accept) skid_d = dec;
      end else if (accept) begin
        out_d = dec;
      end else begin
        out_vld_d = 1'b0;
      end
    end else if (accept) begin
      if (out_vld_q) begin
        skid_d     = dec;
        skid_vld_d = 1'b1;
      end else begin
        out_d     = dec;
        out_vld_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_q      <= '0;
      skid_q     <= '0;
      out_vld_q  <= 1'b0;
      skid_vld_q <= 1'b0;
      rdy_q      <= 1'b0;
    end else begin
      out_q      <= out_d;
      skid_q     <= skid_d;
      out_vld_q  <= out_vld_d;
      skid_vld_q <= skid_vld_d;
      rdy_q      <= !skid_vld_d;
    end
  end

  assign in_ready       = rdy_q;
  assign out_valid      = out_vld_q;
  assign imm_out        = out_q.imm;
  assign fmt_out        = out_q.fmt;
  assign target_out     = out_q.target;
  assign target_vld_out = out_q.tvld;
  assign illegal_out    = out_q.illegal;

endmodule
